mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, 32, address width of requesters and memory.
REQ-002 SHALL have parameter DATA_W, 32, data width (fixed 32; byte-addressed word access).
REQ-003 SHALL have parameter MEM_BYTES, 256, size of attached byte memory.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have ports req_valid_0/1  input  1  requester i has a pending access.
REQ-007 SHALL have ports req_ready_0/1  output  1  requester i's access accepted this cycle.
REQ-008 SHALL have ports req_write_0/1  input  1  1 = store word, 0 = load word.
REQ-009 SHALL have ports req_addr_0/1  input  ADDR_W  byte address; req_wdata_0/1  input  DATA_W  store data.
REQ-010 SHALL have ports resp_valid_0/1  output  1; resp_rdata_0/1  output  DATA_W; resp_err_0/1  output  1.
REQ-011 SHALL have memory-side ports address, writeData (output ADDR_W/DATA_W), memRead, memWrite (output 1), memData (input DATA_W).

Function
REQ-012 SHALL implement FSM states IDLE, ACCESS, RESP; IDLE->ACCESS on handshake, ACCESS->RESP always, RESP->IDLE always.
REQ-013 SHALL in IDLE assert req_ready_i combinationally only for the arbitration winner with req_valid_i=1; at most one ready per cycle.
REQ-014 SHALL arbitrate round-robin: single requester wins; both valid -> grant port not granted last; last_grant updates only on handshake.
REQ-015 SHALL on handshake capture owner, write, addr, wdata into registers; requester inputs are don't-care afterwards.
REQ-016 SHALL deassert req_ready_0/1 in ACCESS and RESP (no new acceptance until IDLE).
REQ-017 SHALL in ACCESS drive address/writeData from captured registers and assert exactly one of memRead/memWrite for exactly one cycle.
REQ-018 SHALL for loads capture memData at the end of ACCESS into the response data register.
REQ-019 SHALL in RESP assert resp_valid of the owner only, for exactly one cycle, no backpressure; resp_rdata = loaded word for loads, 0 for stores.
REQ-020 SHALL hold memRead=memWrite=0, address=writeData=0 in IDLE and RESP.
REQ-021 SHALL give latency: handshake in cycle N, memory access in N+1, resp_valid in N+2, next handshake earliest N+3.
REQ-022 SHALL keep resp_rdata_i/resp_err_i valid only while resp_valid_i=1; outputs SHALL be 0 otherwise.

Reset
REQ-023 SHALL on reset assertion immediately force IDLE, all outputs 0, last_grant=1 (port 0 wins first tie).
REQ-024 SHALL on reset mid-transaction discard the in-flight access with no response; a store already committed by memory is not undone.

Configuration
REQ-025 SHALL with MEM_ARB_BOUNDS_CHECK_EN defined flag an access as error if addr[1:0]!=0 or addr > MEM_BYTES-4.
REQ-026 SHALL with MEM_ARB_BOUNDS_CHECK_EN for an error access keep memRead/memWrite=0 in ACCESS, and in RESP give resp_err=1, resp_rdata=0; timing unchanged.
REQ-027 SHALL without MEM_ARB_BOUNDS_CHECK_EN forward every access to memory and tie resp_err_0/1 to 0.

Structure
REQ-028 SHALL place the FSM state enum, port index constants and MEM_BYTES default in shared package mem_arb_pkg.
REQ-029 SHALL implement round-robin grant in sub-module mem_arb_rr (inputs valid pair, last_grant; output one-hot grant).

Verification
REQ-030 SHALL cover: after reset, port 0 store addr 0x10 data 0xDEADBEEF -> memWrite=1 one cycle at 0x10, resp_valid_0 two cycles after handshake, resp_rdata_0=0.
REQ-031 SHALL cover: port 1 load 0x10 after REQ-030 -> memRead one cycle, resp_rdata_1=0xDEADBEEF, resp_valid_0 stays 0.
REQ-032 SHALL cover: both valid continuously for 6 grants from reset -> grant order 0,1,0,1,0,1, one handshake every 3 cycles.
REQ-033 SHALL cover: reset asserted during ACCESS of a port-0 load -> outputs 0 same cycle, no resp_valid_0, next grant after release goes to port 0.
REQ-034 SHALL cover (MEM_ARB_BOUNDS_CHECK_EN): load at 0x0FD and at 0x100 -> no memRead, resp_err=1, resp_rdata=0; without macro resp_err=0.
REQ-035 SHALL cover: single requester holding valid for 3 back-to-back loads -> handshakes at N, N+3, N+6, ready low in between.

Source files
------------

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_arb_pkg
// Brief   : Shared FSM state type, port indices and default memory size
//           for the two-port memory arbiter.
// Rev     : 1.0
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    localparam int unsigned c_port0             = 0;
    localparam int unsigned c_port1             = 1;
    localparam int unsigned c_mem_bytes_default = 256;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : mem_arbiter_if
// Brief   : Requester handshake and memory-side bus of the arbiter.
//           slave = arbiter side, master = requesters + memory side.
// Rev     : 1.0
// ============================================================================
interface mem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              req_valid_0;
    logic              req_valid_1;
    logic              req_ready_0;
    logic              req_ready_1;
    logic              req_write_0;
    logic              req_write_1;
    logic [ADDR_W-1:0] req_addr_0;
    logic [ADDR_W-1:0] req_addr_1;
    logic [DATA_W-1:0] req_wdata_0;
    logic [DATA_W-1:0] req_wdata_1;

    logic              resp_valid_0;
    logic              resp_valid_1;
    logic [DATA_W-1:0] resp_rdata_0;
    logic [DATA_W-1:0] resp_rdata_1;
    logic              resp_err_0;
    logic              resp_err_1;

    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] writeData;
    logic              memRead;
    logic              memWrite;
    logic [DATA_W-1:0] memData;

    modport slave (
        input  req_valid_0, req_valid_1, req_write_0, req_write_1,
        input  req_addr_0, req_addr_1, req_wdata_0, req_wdata_1,
        output req_ready_0, req_ready_1,
        output resp_valid_0, resp_valid_1, resp_rdata_0, resp_rdata_1,
        output resp_err_0, resp_err_1,
        output address, writeData, memRead, memWrite,
        input  memData
    );

    modport master (
        output req_valid_0, req_valid_1, req_write_0, req_write_1,
        output req_addr_0, req_addr_1, req_wdata_0, req_wdata_1,
        input  req_ready_0, req_ready_1,
        input  resp_valid_0, resp_valid_1, resp_rdata_0, resp_rdata_1,
        input  resp_err_0, resp_err_1,
        input  address, writeData, memRead, memWrite,
        output memData
    );

endinterface : mem_arbiter_if
`default_nettype wire

// File: rtl/mem_arb_rr.sv
`default_nettype none
// ============================================================================
// Module  : mem_arb_rr
// Brief   : Two-way round-robin grant; on a tie the port not granted last wins.
// Rev     : 1.0
// ============================================================================
module mem_arb_rr
    import mem_arb_pkg::*;
(
    input  wire logic [1:0] valid,
    input  wire logic       last_grant,
    output logic      [1:0] grant
);

    always_comb begin
        grant = valid;
        if (valid[c_port0] && valid[c_port1]) begin
            grant = last_grant ? 2'b01 : 2'b10;
        end
    end

endmodule : mem_arb_rr
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_arbiter
// Brief   : Two-requester round-robin arbiter for a single-word byte memory;
//           IDLE -> ACCESS -> RESP per transaction. Optional address bounds
//           checking enabled by defining MEM_ARB_BOUNDS_CHECK_EN.
// Rev     : 1.0
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MEM_BYTES = c_mem_bytes_default
) (
    input  wire logic     clk,
    input  wire logic     reset,
    mem_arbiter_if.slave  bus
);

`ifdef MEM_ARB_BOUNDS_CHECK_EN
    localparam bit c_bounds_en = 1'b1;
`else
    localparam bit c_bounds_en = 1'b0;
`endif

    localparam logic [ADDR_W-1:0] c_last_word = ADDR_W'(MEM_BYTES - 4);

    state_e             state_q,      state_d;
    logic               last_grant_q, last_grant_d;
    logic               owner_q,      owner_d;
    logic               write_q,      write_d;
    logic               err_q,        err_d;
    logic [ADDR_W-1:0]  addr_q,       addr_d;
    logic [DATA_W-1:0]  wdata_q,      wdata_d;
    logic [DATA_W-1:0]  rdata_q,      rdata_d;

    logic [1:0]         w_valid;
    logic [1:0]         w_grant;
    logic [1:0]         w_ready;
    logic               w_handshake;
    logic               w_sel_write;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [DATA_W-1:0]  w_sel_wdata;
    logic               w_sel_err;
    logic               w_in_access;
    logic               w_in_resp;

    assign w_valid = {bus.req_valid_1, bus.req_valid_0};

    mem_arb_rr u_rr (
        .valid      (w_valid),
        .last_grant (last_grant_q),
        .grant      (w_grant)
    );

    // Ready is combinational from the grant but suppressed outside IDLE and
    // while reset is held, so no access can slip in during reset.
    assign w_ready     = (state_q == IDLE && !reset) ? w_grant : 2'b00;
    assign w_handshake = |w_ready;

    assign w_sel_write = w_ready[c_port1] ? bus.req_write_1 : bus.req_write_0;
    assign w_sel_addr  = w_ready[c_port1] ? bus.req_addr_1  : bus.req_addr_0;
    assign w_sel_wdata = w_ready[c_port1] ? bus.req_wdata_1 : bus.req_wdata_0;
    assign w_sel_err   = c_bounds_en &&
                         ((|w_sel_addr[1:0]) || (w_sel_addr > c_last_word));

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        write_d      = write_q;
        err_d        = err_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        case (state_q)
            IDLE: begin
                if (w_handshake) begin
                    state_d      = ACCESS;
                    last_grant_d = w_ready[c_port1];
                    owner_d      = w_ready[c_port1];
                    write_d      = w_sel_write;
                    err_d        = w_sel_err;
                    addr_d       = w_sel_addr;
                    wdata_d      = w_sel_wdata;
                    rdata_d      = '0;
                end
            end
            ACCESS: begin
                state_d = RESP;
                rdata_d = (!write_q && !err_q) ? bus.memData : '0;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            write_q      <= 1'b0;
            err_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            write_q      <= write_d;
            err_q        <= err_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
        end
    end

    assign w_in_access = (state_q == ACCESS);
    assign w_in_resp   = (state_q == RESP);

    always_comb begin
        bus.req_ready_0  = w_ready[c_port0];
        bus.req_ready_1  = w_ready[c_port1];
        bus.address      = w_in_access ? addr_q  : '0;
        bus.writeData    = w_in_access ? wdata_q : '0;
        bus.memRead      = w_in_access && !write_q && !err_q;
        bus.memWrite     = w_in_access &&  write_q && !err_q;
        bus.resp_valid_0 = w_in_resp && !owner_q;
        bus.resp_valid_1 = w_in_resp &&  owner_q;
        bus.resp_rdata_0 = (w_in_resp && !owner_q) ? rdata_q : '0;
        bus.resp_rdata_1 = (w_in_resp &&  owner_q) ? rdata_q : '0;
`ifdef MEM_ARB_BOUNDS_CHECK_EN
        bus.resp_err_0   = w_in_resp && !owner_q && err_q;
        bus.resp_err_1   = w_in_resp &&  owner_q && err_q;
`else
        bus.resp_err_0   = 1'b0;
        bus.resp_err_1   = 1'b0;
`endif
    end

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_arbiter
// Brief   : Self-checking bench: directed scenarios plus random traffic
//           compared cycle by cycle against a transaction-level model.
// Rev     : 1.0
// ============================================================================
module tb_mem_arbiter;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_BYTES(256)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] tb_mem  [64];
    logic [31:0] ref_mem [64];

    assign bus.memData = tb_mem[bus.address[7:2]];
    always @(posedge clk) if (bus.memWrite) tb_mem[bus.address[7:2]] <= bus.writeData;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Transaction-level model: one outstanding access, accept when cyc >= free_at.
    int          free_at = 0;
    int          acc_t   = 0;
    bit          last    = 1'b1;
    bit          has_txn = 1'b0;
    bit          t_owner, t_write, t_err;
    logic [31:0] t_addr, t_wdata, t_rdata;

    int hs_port[$];
    int hs_cyc[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got 0x%08h expected 0x%08h", tag, cyc, obs, exp);
        end
    endtask

    function automatic int word_idx(input logic [31:0] a);
        return int'((a >> 2) & 32'd63);
    endfunction

    function automatic bit model_err(input logic [31:0] a);
`ifdef MEM_ARB_BOUNDS_CHECK_EN
        return (a % 4 != 0) || (a > 32'd252);
`else
        return (a == a) ? 1'b0 : 1'b1;
`endif
    endfunction

    task automatic step(input bit v0, input bit w0, input logic [31:0] a0, input logic [31:0] d0,
                        input bit v1, input bit w1, input logic [31:0] a1, input logic [31:0] d1,
                        input bit rst_v);
        logic        e_r0, e_r1, e_mr, e_mw, e_v0, e_v1, e_e0, e_e1;
        logic [31:0] e_ad, e_wd, e_d0, e_d1;
        int          win;
        @(posedge clk);
        #1;
        reset           = rst_v;
        bus.req_valid_0 = v0; bus.req_write_0 = w0; bus.req_addr_0 = a0; bus.req_wdata_0 = d0;
        bus.req_valid_1 = v1; bus.req_write_1 = w1; bus.req_addr_1 = a1; bus.req_wdata_1 = d1;
        @(negedge clk);

        {e_r0, e_r1, e_mr, e_mw, e_v0, e_v1, e_e0, e_e1} = '0;
        {e_ad, e_wd, e_d0, e_d1} = '0;
        win = -1;
        if (!rst_v) begin
            if (cyc >= free_at) begin
                if (v0 && v1)  win = last ? 0 : 1;
                else if (v0)   win = 0;
                else if (v1)   win = 1;
            end
            e_r0 = (win == 0);
            e_r1 = (win == 1);
            if (has_txn && cyc == acc_t) begin
                e_ad = t_addr;
                e_wd = t_wdata;
                e_mr = !t_write && !t_err;
                e_mw =  t_write && !t_err;
            end
            if (has_txn && cyc == acc_t + 1) begin
                if (!t_owner) begin e_v0 = 1'b1; e_d0 = t_rdata; e_e0 = t_err; end
                else          begin e_v1 = 1'b1; e_d1 = t_rdata; e_e1 = t_err; end
            end
        end

        if (bus.req_ready_0 && v0) begin hs_port.push_back(0); hs_cyc.push_back(cyc); end
        if (bus.req_ready_1 && v1) begin hs_port.push_back(1); hs_cyc.push_back(cyc); end

        check_eq("req_ready_0",  32'(bus.req_ready_0),  32'(e_r0));
        check_eq("req_ready_1",  32'(bus.req_ready_1),  32'(e_r1));
        check_eq("memRead",      32'(bus.memRead),      32'(e_mr));
        check_eq("memWrite",     32'(bus.memWrite),     32'(e_mw));
        check_eq("address",      bus.address,           e_ad);
        check_eq("writeData",    bus.writeData,         e_wd);
        check_eq("resp_valid_0", 32'(bus.resp_valid_0), 32'(e_v0));
        check_eq("resp_valid_1", 32'(bus.resp_valid_1), 32'(e_v1));
        check_eq("resp_rdata_0", bus.resp_rdata_0,      e_d0);
        check_eq("resp_rdata_1", bus.resp_rdata_1,      e_d1);
        check_eq("resp_err_0",   32'(bus.resp_err_0),   32'(e_e0));
        check_eq("resp_err_1",   32'(bus.resp_err_1),   32'(e_e1));

        if (rst_v) begin
            has_txn = 1'b0;
            free_at = cyc + 1;
            last    = 1'b1;
        end else begin
            if (e_mw) ref_mem[word_idx(t_addr)] = t_wdata;
            if (has_txn && cyc == acc_t) t_rdata = e_mr ? ref_mem[word_idx(t_addr)] : 32'h0;
            if (win >= 0) begin
                has_txn = 1'b1;
                t_owner = (win == 1);
                t_write = (win == 1) ? w1 : w0;
                t_addr  = (win == 1) ? a1 : a0;
                t_wdata = (win == 1) ? d1 : d0;
                t_err   = model_err(t_addr);
                acc_t   = cyc + 1;
                free_at = cyc + 3;
                last    = (win == 1);
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 15);
        if (r == 0) return 32'h0000_00FD;
        if (r == 1) return 32'h0000_0100;
        if (r == 2) return $urandom;
        return 32'($urandom_range(0, 63)) << 2;
    endfunction

    initial begin
        bus.req_valid_0 = 0; bus.req_write_0 = 0; bus.req_addr_0 = 0; bus.req_wdata_0 = 0;
        bus.req_valid_1 = 0; bus.req_write_1 = 0; bus.req_addr_1 = 0; bus.req_wdata_1 = 0;
        for (int i = 0; i < 64; i++) begin
            tb_mem[i]  = $urandom;
            ref_mem[i] = tb_mem[i];
        end

        // Reset state, with requests already pending.
        step(1, 0, 32'h10, 0, 1, 0, 32'h20, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);

        // Port 0 store then port 1 load of the same word.
        step(1, 1, 32'h10, 32'hDEAD_BEEF, 0, 0, 0, 0, 0);
        idle(3);
        step(0, 0, 0, 0, 1, 0, 32'h10, 0, 0);
        idle(3);

        // Both valid continuously from reset: strict alternation, 3-cycle spacing.
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        hs_port.delete(); hs_cyc.delete();
        for (int i = 0; i < 18; i++)
            step(1, 0, 32'($urandom_range(0, 63)) << 2, 0, 1, 0, 32'($urandom_range(0, 63)) << 2, 0, 0);
        check_eq("rr_grant_count", 32'(hs_port.size()), 32'd6);
        for (int i = 0; i < hs_port.size(); i++) begin
            check_eq("rr_grant_order", 32'(hs_port[i]), 32'(i % 2));
            if (i > 0) check_eq("rr_grant_spacing", 32'(hs_cyc[i] - hs_cyc[i-1]), 32'd3);
        end
        idle(3);

        // Reset during ACCESS of a port-0 load, then a tie goes to port 0.
        step(1, 0, 32'h24, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        hs_port.delete(); hs_cyc.delete();
        step(1, 0, 32'h28, 0, 1, 0, 32'h2C, 0, 0);
        check_eq("post_reset_grant", (hs_port.size() > 0) ? 32'(hs_port[0]) : 32'hFFFF_FFFF, 32'd0);
        idle(4);

        // Out-of-range / misaligned loads.
        step(0, 0, 0, 0, 1, 0, 32'h0FD, 0, 0);
        idle(3);
        step(0, 0, 0, 0, 1, 0, 32'h100, 0, 0);
        idle(3);

        // Single requester holding valid for three loads.
        hs_port.delete(); hs_cyc.delete();
        for (int i = 0; i < 9; i++) step(1, 0, 32'(i) << 2, 0, 0, 0, 0, 0, 0);
        check_eq("b2b_count", 32'(hs_cyc.size()), 32'd3);
        for (int i = 1; i < hs_cyc.size(); i++)
            check_eq("b2b_spacing", 32'(hs_cyc[i] - hs_cyc[i-1]), 32'd3);
        idle(3);

        // Random traffic with occasional reset.
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_addr(), $urandom,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_addr(), $urandom,
                 ($urandom_range(0, 99) == 0));
        end
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_mem_arbiter
`default_nettype wire
